// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with two write ports, optional write-to-read
// bypass and a per-register busy scoreboard for issue-time hazard detection.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   we0/wa0/wd0           write port 0 (ALU writeback)
//   we1/wa1/wd1           write port 1 (load writeback, wins on address collision)
//   rs_addr               NUM_RD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rs_data               NUM_RD packed read data, combinational
//   rs_busy               per-read-port busy flag, combinational
//   iss_valid/iss_addr    issue strobe marking the destination register busy
module reg_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*ADDR_W-1:0] rs_addr,
  output logic [NUM_RD*DATA_W-1:0] rs_data,
  output logic [NUM_RD-1:0]        rs_busy,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr
);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;

  // True for addresses backed by a writable register (in range, not the hardwired zero).
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W + 1)'(DEPTH)) && !(ZERO_REG && (a == '0));
  endfunction

  logic w0_ok, w1_ok, iss_ok;

  assign w0_ok  = we0 && addr_ok(wa0);
  assign w1_ok  = we1 && addr_ok(wa1);
  assign iss_ok = iss_valid && addr_ok(iss_addr);

  // Per-register address compare keeps every index in range for any DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if (w1_ok && (wa1 == ADDR_W'(r))) begin
          regs_q[r] <= wd1;
        end else if (w0_ok && (wa0 == ADDR_W'(r))) begin
          regs_q[r] <= wd0;
        end
        // A new producer issued in the same cycle as the old one writes back keeps it busy.
        if (iss_ok && (iss_addr == ADDR_W'(r))) begin
          busy_q[r] <= 1'b1;
        end else if ((w0_ok && (wa0 == ADDR_W'(r))) || (w1_ok && (wa1 == ADDR_W'(r)))) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_val;
    logic              rd_busy;
    rs_data = '0;
    rs_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_addr = rs_addr[i*ADDR_W +: ADDR_W];
      rd_val  = '0;
      rd_busy = 1'b0;
      if (addr_ok(rd_addr)) begin
        for (int unsigned r = 0; r < DEPTH; r++) begin
          if (rd_addr == ADDR_W'(r)) begin
            rd_val  = regs_q[r];
            rd_busy = busy_q[r];
          end
        end
        if (BYPASS) begin
          if (w1_ok && (wa1 == rd_addr)) begin
            rd_val  = wd1;
            rd_busy = 1'b0;
          end else if (w0_ok && (wa0 == rd_addr)) begin
            rd_val  = wd0;
            rd_busy = 1'b0;
          end
        end
      end
      rs_data[i*DATA_W +: DATA_W] = rd_val;
      rs_busy[i]                  = rd_busy;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed testbench for reg_file_mp: a default bypassing instance, a non-bypassing
// instance sharing its stimulus, and a 24-deep, 64-bit, 3-read-port instance.
module tb_reg_file_mp;

  localparam logic [63:0] K = 64'h0101010101010101;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Shared stimulus for the bypass and no-bypass instances.
  logic        we0, we1, iss_valid;
  logic [4:0]  wa0, wa1, iss_addr;
  logic [31:0] wd0, wd1;
  logic [9:0]  rs_addr;
  logic [63:0] a_data, b_data;
  logic [1:0]  a_busy, b_busy;

  // Stimulus for the parameter-sweep instance.
  logic        c_we0, c_we1, c_iss_valid;
  logic [4:0]  c_wa0, c_wa1, c_iss_addr;
  logic [63:0] c_wd0, c_wd1;
  logic [14:0] c_rs_addr;
  logic [191:0] c_data;
  logic [2:0]  c_busy;

  reg_file_mp #(.BYPASS(1'b1)) u_dut_a (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .rs_addr(rs_addr), .rs_data(a_data), .rs_busy(a_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr)
  );

  reg_file_mp #(.BYPASS(1'b0)) u_dut_b (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .rs_addr(rs_addr), .rs_data(b_data), .rs_busy(b_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr)
  );

  reg_file_mp #(.DATA_W(64), .DEPTH(24), .ADDR_W(5), .NUM_RD(3)) u_dut_c (
    .clk(clk), .reset(reset),
    .we0(c_we0), .wa0(c_wa0), .wd0(c_wd0), .we1(c_we1), .wa1(c_wa1), .wd1(c_wd1),
    .rs_addr(c_rs_addr), .rs_data(c_data), .rs_busy(c_busy),
    .iss_valid(c_iss_valid), .iss_addr(c_iss_addr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected contents of the sweep instance after its fill loop.
  function automatic logic [63:0] exp_c(input int a);
    return (a >= 1 && a <= 23) ? 64'(a) * K : 64'h0;
  endfunction

  initial begin
    reset = 1'b1;
    {we0, we1, iss_valid} = '0;
    {wa0, wa1, iss_addr} = '0;
    {wd0, wd1} = '0;
    rs_addr = '0;
    {c_we0, c_we1, c_iss_valid} = '0;
    {c_wa0, c_wa1, c_iss_addr} = '0;
    {c_wd0, c_wd1} = '0;
    c_rs_addr = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    rs_addr = {5'd2, 5'd1};
    #1;
    check("rst_data_a", a_data, 64'h0);
    check("rst_busy_a", 64'(a_busy), 64'h0);

    // Basic writes on both ports
    we0 = 1'b1; wa0 = 5'd1; wd0 = 32'hA5A5A5A5;
    tick();
    we0 = 1'b0;
    we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h5A5A5A5A;
    tick();
    we1 = 1'b0;
    #1;
    check("wr_data_a", a_data, 64'h5A5A5A5A_A5A5A5A5);
    check("wr_data_b", b_data, 64'h5A5A5A5A_A5A5A5A5);
    check("wr_busy_a", 64'(a_busy), 64'h0);

    // Collision: load port wins
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h11111111;
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h22222222;
    tick();
    {we0, we1} = '0;
    rs_addr = {5'd0, 5'd3};
    #1;
    check("collide_a", 64'(a_data[31:0]), 64'h22222222);
    check("collide_b", 64'(b_data[31:0]), 64'h22222222);

    // Zero register: not forwarded, not stored
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
    #1;
    check("zero_byp_a", 64'(a_data[63:32]), 64'h0);
    tick();
    we0 = 1'b0;
    #1;
    check("zero_a", 64'(a_data[63:32]), 64'h0);
    check("zero_b", 64'(b_data[63:32]), 64'h0);

    // Bypass vs. no bypass
    rs_addr = {5'd1, 5'd4};
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h44444444;
    #1;
    check("byp_same_a", 64'(a_data[31:0]), 64'h44444444);
    check("nobyp_same_b", 64'(b_data[31:0]), 64'h0);
    check("byp_other_a", 64'(a_data[63:32]), 64'hA5A5A5A5);
    tick();
    we0 = 1'b0;
    #1;
    check("byp_next_a", 64'(a_data[31:0]), 64'h44444444);
    check("nobyp_next_b", 64'(b_data[31:0]), 64'h44444444);

    // Scoreboard: issue visible only on the following cycle
    rs_addr = {5'd6, 5'd5};
    iss_valid = 1'b1; iss_addr = 5'd5;
    #1;
    check("iss_same_a", 64'(a_busy[0]), 64'h0);
    tick();
    iss_valid = 1'b0;
    #1;
    check("iss_next_a", 64'(a_busy[0]), 64'h1);
    check("iss_next_b", 64'(b_busy[0]), 64'h1);
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h55555555;
    #1;
    check("clr_byp_a", 64'(a_busy[0]), 64'h0);
    check("clr_nobyp_b", 64'(b_busy[0]), 64'h1);
    tick();
    we1 = 1'b0;
    #1;
    check("clr_after_a", 64'(a_busy[0]), 64'h0);
    check("clr_after_b", 64'(b_busy[0]), 64'h0);

    // Issue and writeback to the same register: stays busy
    iss_valid = 1'b1; iss_addr = 5'd6;
    we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h66666666;
    tick();
    {iss_valid, we0} = '0;
    #1;
    check("iss_wr_a", 64'(a_busy[1]), 64'h1);
    check("iss_wr_data_a", 64'(a_data[63:32]), 64'h66666666);

    // Issue to register 0 is ignored
    iss_valid = 1'b1; iss_addr = 5'd0;
    tick();
    iss_valid = 1'b0;
    rs_addr = {5'd0, 5'd0};
    #1;
    check("iss_zero_a", 64'(a_busy), 64'h0);

    // Reset mid-operation dominates a concurrent write and clears busy bits
    iss_valid = 1'b1; iss_addr = 5'd7;
    tick();
    iss_valid = 1'b0;
    rs_addr = {5'd6, 5'd7};
    #1;
    check("pre_rst_busy_a", 64'(a_busy), 64'h3);
    reset = 1'b1;
    we0 = 1'b1; wa0 = 5'd1; wd0 = 32'hDEADBEEF;
    tick();
    reset = 1'b0;
    we0 = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rs_addr = {5'(a), 5'(a)};
      #1;
      check($sformatf("mid_rst_data_a[%0d]", a), a_data, 64'h0);
      check($sformatf("mid_rst_busy_a[%0d]", a), 64'(a_busy), 64'h0);
      check($sformatf("mid_rst_data_b[%0d]", a), b_data, 64'h0);
    end

    // Sweep instance: out-of-range write dropped, reads of out-of-range return 0
    c_we0 = 1'b1; c_wa0 = 5'd30; c_wd0 = '1;
    c_rs_addr = {5'd31, 5'd24, 5'd30};
    #1;
    check("c_oor_byp", c_data[63:0], 64'h0);
    tick();
    c_we0 = 1'b0;
    #1;
    check("c_oor_30", c_data[63:0], 64'h0);
    check("c_oor_24", c_data[127:64], 64'h0);
    check("c_oor_31", c_data[191:128], 64'h0);

    // Fill 1..23 alternating between write ports
    for (int i = 1; i <= 23; i++) begin
      if (i % 2 == 1) begin
        c_we0 = 1'b1; c_wa0 = 5'(i); c_wd0 = 64'(i) * K;
      end else begin
        c_we1 = 1'b1; c_wa1 = 5'(i); c_wd1 = 64'(i) * K;
      end
      tick();
      {c_we0, c_we1} = '0;
    end
    for (int i = 1; i <= 23; i++) begin
      c_rs_addr = {5'((i % 23) + 1), 5'(24 - i), 5'(i)};
      #1;
      check($sformatf("c_rd0[%0d]", i), c_data[63:0], exp_c(i));
      check($sformatf("c_rd1[%0d]", i), c_data[127:64], exp_c(24 - i));
      check($sformatf("c_rd2[%0d]", i), c_data[191:128], exp_c((i % 23) + 1));
    end
    c_rs_addr = {5'd0, 5'd30, 5'd24};
    #1;
    check("c_post_24", c_data[63:0], 64'h0);
    check("c_post_30", c_data[127:64], 64'h0);
    check("c_post_0", c_data[191:128], 64'h0);
    check("c_busy", 64'(c_busy), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file that succeeds the fixed 32x32, 2-read/1-write register file in the CPU datapath.
- Generalised in data width, depth and read-port count.
- Adds a second write port for the load/ALU writeback split, optional write-to-read bypass, and a per-register busy scoreboard used by issue logic for hazard detection.

Parameters:
- DATA_W, 32: register width in bits.
- DEPTH, 32: number of architectural registers (2..2**ADDR_W).
- ADDR_W, 5: address width.
- NUM_RD, 2: number of read ports (1..4).
- ZERO_REG, 1: 1 = register 0 hardwired to zero, never written, never busy.
- BYPASS, 1: 1 = same-cycle write data forwarded to read ports.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- we0  in  1  write enable, port 0 (ALU writeback).
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (load writeback).
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- rs_addr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- rs_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rs_busy  out  NUM_RD  per-read-port busy flag, combinational.
- iss_valid  in  1  issue strobe; marks iss_addr busy.
- iss_addr  in  ADDR_W  destination register being issued.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset: all DEPTH registers cleared to 0 and all busy bits cleared on the edge where reset=1. Reset dominates writes and issue in the same cycle.
- Outputs under reset: rs_data and rs_busy are combinational, so they read 0 for every address on the cycle after the reset edge.
- Writes: on rising clk, if weN=1 and waN<DEPTH (and waN!=0 when ZERO_REG=1), reg[waN] <= wdN.
  - Out-of-range or zero-register writes are silently dropped.
- Write collision: we0=we1=1 with wa0==wa1 -> port 1 value is stored (load priority).
- Reads: asynchronous, no clock latency.
  - rs_data[i] = 0 if rs_addr[i] >= DEPTH, or if ZERO_REG=1 and rs_addr[i]==0.
  - When BYPASS=1 and a valid in-range write targets rs_addr[i] this cycle, rs_data[i] = write data. Port 1 data wins if both ports hit.
  - Otherwise rs_data[i] = reg[rs_addr[i]].
  - When BYPASS=0, write data becomes visible on the cycle after the write edge.
- Scoreboard: busy[DEPTH] bits.
  - Set: iss_valid=1 sets busy[iss_addr] at the edge. Ignored for register 0 when ZERO_REG=1 and for addresses >= DEPTH.
  - Clear: any valid write (we0 or we1) to reg r clears busy[r] at the edge.
  - Simultaneous: issue and write to the same r in one cycle -> busy[r] stays 1 (new producer wins).
  - Outputs:
    - rs_busy[i] = busy[rs_addr[i]].
    - When BYPASS=1, rs_busy[i] is forced 0 if a valid write to that address occurs this cycle.
    - rs_busy[i] = 0 for register 0 (when ZERO_REG=1) and for out-of-range addresses.
  - An issue becomes visible on rs_busy only the cycle after iss_valid.
- Read ports are independent. Any number of ports may read the same address.
- No X propagation: every rs_data and rs_busy bit is defined for every address value.

Test Plan:
1. Reset is held for 2 cycles, then writes are issued: we0, wa0=1, wd0=A5A5A5A5; then we1, wa1=2, wd1=5A5A5A5A. Next cycle, read with rs_addr port0=1, port1=2 -> rs_data = A5A5A5A5 / 5A5A5A5A, rs_busy = 00.
2. Collision and zero register: we0=we1=1, wa0=wa1=3, wd0=11111111, wd1=22222222 -> reg3 reads 22222222. Then we0=1, wa0=0, wd0=FFFFFFFF -> reg0 still reads 00000000.
3. Bypass with BYPASS=1: rs_addr port0=4, we0=1, wa0=4, wd0=44444444 in the same cycle -> rs_data[0]=44444444 in that cycle. With BYPASS=0 -> old value (0) in that cycle, 44444444 on the next.
4. Scoreboard:
   - iss_valid=1, iss_addr=5 -> rs_busy=1 for addr 5 on the next cycle.
   - we1=1, wa1=5 -> rs_busy=0 in that cycle (bypass) and thereafter.
   - iss_valid and we0 both targeting 6 in one cycle -> busy[6]=1 afterwards.
   - iss_addr=0 -> never busy.
5. Parameter sweep DEPTH=24, ADDR_W=5, NUM_RD=3, DATA_W=64: a write to addr 30 is dropped and a read of addr 30 returns 0. Registers 1..23 are each written with their own index times 0x0101010101010101, and all three read ports return correct values.
6. Reset mid-operation: registers 1..5 are written and reg 7 is marked busy. Then reset=1 for one cycle with we0=1, wa0=1, wd0=DEADBEEF asserted. Next cycle -> all reads return 0 and all rs_busy=0.
